// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped target bus between NUM_MASTERS VProc bus masters.
// A grant is held for a whole access, including every word of a burst, so bursts never interleave.
module vproc_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [32*NUM_MASTERS-1:0] MAddr,
  input  logic [4*NUM_MASTERS-1:0]  MBE,
  input  logic [NUM_MASTERS-1:0]    MWE,
  input  logic [NUM_MASTERS-1:0]    MRD,
  input  logic [32*NUM_MASTERS-1:0] MDataOut,
  input  logic [12*NUM_MASTERS-1:0] MBurst,
  input  logic [NUM_MASTERS-1:0]    MBurstLast,
  output logic [31:0]               MDataIn,
  output logic [NUM_MASTERS-1:0]    MWRAck,
  output logic [NUM_MASTERS-1:0]    MRDAck,
  output logic [31:0]               SAddr,
  output logic [3:0]                SBE,
  output logic                      SWE,
  output logic                      SRD,
  output logic [31:0]               SDataOut,
  input  logic [31:0]               SDataIn,
  input  logic                      SWRAck,
  input  logic                      SRDAck,
  output logic                      GntValid,
  output logic [IDX_WIDTH-1:0]      GntIdx,
  output logic                      SpuriousAck
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   gnt_idx;
  logic [IDX_WIDTH-1:0]   last_idx;
  logic [IDX_WIDTH-1:0]   winner;
  logic                   gnt_valid;
  logic                   spurious;

  logic [NUM_MASTERS-1:0] req;
  logic                   any_req;
  logic                   granted;
  logic                   found;

  logic [31:0]            g_addr;
  logic [31:0]            g_wdata;
  logic [3:0]             g_be;
  logic                   g_we;
  logic                   g_rd;
  logic [11:0]            g_burst;
  logic                   g_last;
  logic                   g_req;

  logic                   wr_done;
  logic                   rd_done;
  logic                   access_done;
  logic                   final_word;

  assign req     = MWE | MRD;
  assign any_req = |req;
  assign granted = (state == GRANT);

  // Rotating priority: candidate k steps after the last winner, with wrap.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && req[i] && (((int'(last_idx) + k) % NUM_MASTERS) == i)) begin
          winner = IDX_WIDTH'(i);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_be    = '0;
    g_we    = 1'b0;
    g_rd    = 1'b0;
    g_burst = '0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_idx == IDX_WIDTH'(i)) begin
        g_addr  = MAddr[32*i +: 32];
        g_wdata = MDataOut[32*i +: 32];
        g_be    = MBE[4*i +: 4];
        g_we    = MWE[i];
        g_rd    = MRD[i];
        g_burst = MBurst[12*i +: 12];
        g_last  = MBurstLast[i];
      end
    end
  end

  assign g_req    = g_we | g_rd;
  assign SAddr    = granted ? g_addr  : '0;
  assign SBE      = granted ? g_be    : '0;
  assign SDataOut = granted ? g_wdata : '0;
  assign SWE      = granted & g_we;
  assign SRD      = granted & g_rd;
  assign MDataIn  = SDataIn;

  assign wr_done     = SWRAck & SWE;
  assign rd_done     = SRDAck & SRD;
  assign access_done = wr_done | rd_done;
  assign final_word  = (g_burst == 12'd0) | g_last;

  always_comb begin
    MWRAck = '0;
    MRDAck = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (granted && (gnt_idx == IDX_WIDTH'(i))) begin
        MWRAck[i] = wr_done;
        MRDAck[i] = rd_done;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      last_idx  <= IDX_WIDTH'(NUM_MASTERS - 1);
      spurious  <= 1'b0;
    end else begin
      if ((SWRAck & ~SWE) | (SRDAck & ~SRD)) begin
        spurious <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= GRANT;
            gnt_valid <= 1'b1;
            gnt_idx   <= winner;
            last_idx  <= winner;
          end
        end
        GRANT: begin
          // A withdrawn request releases the bus just like a completed final word.
          if (!g_req || (access_done && final_word)) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign GntValid    = gnt_valid;
  assign GntIdx      = gnt_idx;
  assign SpuriousAck = spurious;

endmodule
